gauss_moment_estimator: RTL

Consumer-side counterpart of the Q7.24 Gaussian velocity-perturbation generator. On `start` it drives the generator's `Enable` for exactly 2^LOG2N cycles and captures one `randnum` sample per cycle. It accumulates sum and sum of squares, then reports sample mean and variance in the same fixed-point format. It is used on-chip to calibrate the generator's OFFSET/SHIFTAMT settings for UX/UY, and in verification of the LBM initial-condition path.

---
 rtl/gauss_moment_estimator.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gauss_moment_estimator.sv
// gauss_moment_estimator
// Drives a Gaussian generator's Enable for 2^LOG2N cycles, captures one sample per
// cycle, and reports the sample mean and population variance in the samples' own
// signed fixed-point format.
// Optional feature: define GAUSS_MOMENT_MINMAX_EN to track the min/max captured
// sample of each run; otherwise min_val/max_val are tied to 0.
module gauss_moment_estimator #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRACTIONAL_BITS = 24,
  parameter int LOG2N           = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  gen_enable,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] mean,
  output logic [DATA_WIDTH-1:0] variance,
  output logic [DATA_WIDTH-1:0] min_val,
  output logic [DATA_WIDTH-1:0] max_val
);

  localparam int SW = DATA_WIDTH + LOG2N;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN1, DRAIN2, MEAN, VAR} state_t;

  state_t                       state;
  logic [LOG2N-1:0]             cnt;
  logic signed [DATA_WIDTH-1:0] s_reg;
  logic                         s_valid;
  logic [PW-1:0]                sq_reg;
  logic                         sq_valid;
  logic signed [SW-1:0]         sum;
  logic [PW-1:0]                sumsq;

  logic run_start;
  logic capture;

  logic signed [SW-1:0]         s_sum_ext;
  logic signed [PW-1:0]         s_ext;
  logic signed [PW-1:0]         s_prod;
  logic signed [PW-1:0]         s_prod_sh;
  logic [DATA_WIDTH-1:0]        mean_next;
  logic signed [PW-1:0]         m_ext;
  logic signed [PW-1:0]         m_prod;
  logic signed [PW-1:0]         m_prod_sh;
  logic [PW-1:0]                sumsq_div;
  logic signed [PW:0]           v;
  logic [DATA_WIDTH-1:0]        var_next;

  assign run_start  = (state == IDLE) && start;
  assign capture    = (state == ACCUM);
  assign gen_enable = capture;

  // Square of the captured sample, rescaled back to the fixed-point format.
  assign s_sum_ext = {{LOG2N{s_reg[DATA_WIDTH-1]}}, s_reg};
  assign s_ext     = {{DATA_WIDTH{s_reg[DATA_WIDTH-1]}}, s_reg};
  assign s_prod    = s_ext * s_ext;
  assign s_prod_sh = s_prod >>> FRACTIONAL_BITS;

  // Dropping the low LOG2N bits of sum is an arithmetic shift; it always fits.
  assign mean_next = sum[SW-1:LOG2N];

  // Variance = E[x^2] - mean^2, in one bit wider than the product so the sign survives.
  assign m_ext     = {{DATA_WIDTH{mean[DATA_WIDTH-1]}}, mean};
  assign m_prod    = m_ext * m_ext;
  assign m_prod_sh = m_prod >>> FRACTIONAL_BITS;
  assign sumsq_div = sumsq >> LOG2N;
  assign v         = {1'b0, sumsq_div} - {m_prod_sh[PW-1], m_prod_sh};

  // Clamp truncation-induced negatives to 0 and saturate to the largest positive value.
  always_comb begin
    var_next = v[DATA_WIDTH-1:0];
    if (v[PW]) begin
      var_next = '0;
    end else if (|v[PW-1:DATA_WIDTH-1]) begin
      var_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Capture / square / accumulate pipeline; cleared on reset and at the start of a run.
  always_ff @(posedge Clk) begin
    if (!Reset || run_start) begin
      s_reg    <= '0;
      s_valid  <= 1'b0;
      sq_reg   <= '0;
      sq_valid <= 1'b0;
      sum      <= '0;
      sumsq    <= '0;
    end else begin
      s_valid  <= capture;
      sq_valid <= s_valid;
      if (capture) begin
        s_reg <= sample;
      end
      if (s_valid) begin
        sum    <= sum + s_sum_ext;
        sq_reg <= s_prod_sh;
      end
      if (sq_valid) begin
        sumsq <= sumsq + sq_reg;
      end
    end
  end

  // Run sequencing with registered busy/done/mean/variance.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mean     <= '0;
      variance <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= DRAIN1;
          end
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: state <= MEAN;
        MEAN: begin
          mean  <= mean_next;
          state <= VAR;
        end
        VAR: begin
          variance <= var_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAUSS_MOMENT_MINMAX_EN
  logic first_cap;
  assign first_cap = (cnt == '0);

  // Track extremes of the current run; the first capture loads both.
  always_ff @(posedge Clk) begin
    if (!Reset || run_start) begin
      min_val <= '0;
      max_val <= '0;
    end else if (capture) begin
      if (first_cap || ($signed(sample) < $signed(min_val))) begin
        min_val <= sample;
      end
      if (first_cap || ($signed(sample) > $signed(max_val))) begin
        max_val <= sample;
      end
    end
  end
`else
  assign min_val = '0;
  assign max_val = '0;
`endif

endmodule
